alu_uart_interface: RTL and testbench
=====================================

ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 Parameter N, default 8, data width of operands and result.
REQ-002 Parameter NB_OP, default 6, opcode width.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_rx_data  input  8  byte from UART receiver, valid while i_rx_done=1.
REQ-006 i_rx_done  input  1  one-cycle pulse: new received byte.
REQ-007 i_tx_done  input  1  one-cycle pulse: UART transmitter finished current byte.
REQ-008 i_resultado  input  N  ALU result.
REQ-009 i_zero, i_overflow, i_carry  input  1 each  ALU flags.
REQ-010 o_datoA  output  N  operand A to ALU.
REQ-011 o_datoB  output  N  operand B to ALU.
REQ-012 o_operacion  output  NB_OP  opcode to ALU.
REQ-013 o_tx_data  output  8  byte to UART transmitter.
REQ-014 o_tx_start  output  1  one-cycle pulse: start transmission of o_tx_data.
REQ-015 o_busy  output  1  high in any state other than WAIT_A.

Function
REQ-016 States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_TX_RES, SEND_FLG, WAIT_TX_FLG.
REQ-017 WAIT_A: on i_rx_done, register i_rx_data[N-1:0] into o_datoA; next state WAIT_B.
REQ-018 WAIT_B: on i_rx_done, register i_rx_data[N-1:0] into o_datoB; next WAIT_OP.
REQ-019 WAIT_OP: on i_rx_done, register i_rx_data[NB_OP-1:0] into o_operacion (bits 7:NB_OP ignored); next EXEC.
REQ-020 Without i_rx_done, WAIT_A/WAIT_B/WAIT_OP hold state and operand registers.
REQ-021 EXEC lasts exactly one cycle: capture i_resultado into internal result register and {5'b0, i_carry, i_overflow, i_zero} into internal flags register; next SEND_RES.
REQ-022 SEND_RES lasts one cycle: o_tx_start=1, o_tx_data=result register (zero-extended/truncated to 8 bits); next WAIT_TX_RES.
REQ-023 WAIT_TX_RES: o_tx_data held at result; on i_tx_done go to SEND_FLG.
REQ-024 SEND_FLG lasts one cycle: o_tx_start=1, o_tx_data=flags register; next WAIT_TX_FLG.
REQ-025 WAIT_TX_FLG: o_tx_data held at flags; on i_tx_done go to WAIT_A.
REQ-026 o_tx_start SHALL be 1 only in SEND_RES and SEND_FLG, never two consecutive cycles.
REQ-027 Latency: i_rx_done of opcode byte at edge k -> o_tx_start high in cycle after edge k+2.
REQ-028 i_rx_done in EXEC, SEND_*, WAIT_TX_* SHALL be ignored; byte discarded, no register change.
REQ-029 i_tx_done outside WAIT_TX_RES/WAIT_TX_FLG SHALL be ignored.
REQ-030 o_datoA, o_datoB, o_operacion SHALL stay stable from capture until overwritten by a later frame; they are not cleared on return to WAIT_A.
REQ-031 i_rx_done and i_tx_done simultaneous: only the one relevant to current state acts.

Reset
REQ-032 While i_reset=1, state=WAIT_A; o_datoA, o_datoB, o_operacion, o_tx_data, result and flags registers = 0; o_tx_start=0; o_busy=0.
REQ-033 Reset asserted mid-frame or mid-transmission SHALL abort immediately; partial frame discarded; no o_tx_start after release until a full new 3-byte frame.

Verification
REQ-034 ADD: rx 0x05, 0x03, 0x20; ALU model returns 0x08 -> one o_tx_start with 0x08, after i_tx_done one o_tx_start with 0x00.
REQ-035 SUB to zero: rx 0x07, 0x07, 0x22 -> tx 0x00 then 0x01 (zero flag).
REQ-036 Overflow/carry: rx 0x7F, 0x01, 0x20 -> tx 0x80 then 0x02; rx 0xFF, 0x01, 0x20 -> tx 0x00 then 0x05.
REQ-037 Extra byte 0xAA pulsed during WAIT_TX_RES -> ignored; o_datoA unchanged; next frame 0x01,0x01,0x20 yields tx 0x02.
REQ-038 Reset after two bytes (0x10, 0x20) -> all outputs 0, state WAIT_A; next frame 0x03,0x04,0x24 yields tx 0x00 then 0x01.
REQ-039 Opcode byte 0xE6 -> o_operacion=0x26; o_tx_start never asserted before i_tx_done sequencing completes.

Source files
------------

// File: rtl/alu_uart_interface.sv
// Bridges a byte-oriented UART to a combinational ALU: gathers A, B and opcode
// bytes, then transmits the result byte followed by a flags byte {5'b0,C,V,Z}.
module alu_uart_interface #(
    parameter int N     = 8,
    parameter int NB_OP = 6
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_done,
    input  logic             i_tx_done,
    input  logic [N-1:0]     i_resultado,
    input  logic             i_zero,
    input  logic             i_overflow,
    input  logic             i_carry,
    output logic [N-1:0]     o_datoA,
    output logic [N-1:0]     o_datoB,
    output logic [NB_OP-1:0] o_operacion,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_start,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        WAIT_A      = 3'd0,
        WAIT_B      = 3'd1,
        WAIT_OP     = 3'd2,
        EXEC        = 3'd3,
        SEND_RES    = 3'd4,
        WAIT_TX_RES = 3'd5,
        SEND_FLG    = 3'd6,
        WAIT_TX_FLG = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_ld_a;
    logic             w_ld_b;
    logic             w_ld_op;
    logic             w_ld_exec;
    logic             w_start_res;
    logic             w_start_flg;

    logic [N-1:0]     r_dato_a;
    logic [N-1:0]     r_dato_b;
    logic [NB_OP-1:0] r_operacion;
    logic [N-1:0]     r_result;
    logic [2:0]       r_flags;
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic             r_busy;

    logic [N-1:0]     w_rx_operand;
    logic [7:0]       w_res_byte;

    // Width adaptation between the 8-bit UART byte and the N-bit datapath.
    generate
        if (N > 8) begin : g_wide
            assign w_rx_operand = {{(N-8){1'b0}}, i_rx_data};
            assign w_res_byte   = r_result[7:0];
        end else if (N == 8) begin : g_equal
            assign w_rx_operand = i_rx_data;
            assign w_res_byte   = r_result;
        end else begin : g_narrow
            assign w_rx_operand = i_rx_data[N-1:0];
            assign w_res_byte   = {{(8-N){1'b0}}, r_result};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state load/start strobes.
    always_comb begin
        w_state_next = r_state;
        w_ld_a       = 1'b0;
        w_ld_b       = 1'b0;
        w_ld_op      = 1'b0;
        w_ld_exec    = 1'b0;
        w_start_res  = 1'b0;
        w_start_flg  = 1'b0;
        case (r_state)
            WAIT_A: begin
                if (i_rx_done) begin
                    w_ld_a       = 1'b1;
                    w_state_next = WAIT_B;
                end else begin
                    w_state_next = WAIT_A;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    w_ld_b       = 1'b1;
                    w_state_next = WAIT_OP;
                end else begin
                    w_state_next = WAIT_B;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    w_ld_op      = 1'b1;
                    w_state_next = EXEC;
                end else begin
                    w_state_next = WAIT_OP;
                end
            end
            EXEC: begin
                w_ld_exec    = 1'b1;
                w_state_next = SEND_RES;
            end
            SEND_RES: begin
                w_start_res  = 1'b1;
                w_state_next = WAIT_TX_RES;
            end
            WAIT_TX_RES: begin
                if (i_tx_done) begin
                    w_state_next = SEND_FLG;
                end else begin
                    w_state_next = WAIT_TX_RES;
                end
            end
            SEND_FLG: begin
                w_start_flg  = 1'b1;
                w_state_next = WAIT_TX_FLG;
            end
            WAIT_TX_FLG: begin
                if (i_tx_done) begin
                    w_state_next = WAIT_A;
                end else begin
                    w_state_next = WAIT_TX_FLG;
                end
            end
            default: begin
                w_state_next = WAIT_A;
            end
        endcase
    end

    // Operand, result and transmit registers; every output is driven from a flop.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_dato_a    <= {N{1'b0}};
            r_dato_b    <= {N{1'b0}};
            r_operacion <= {NB_OP{1'b0}};
            r_result    <= {N{1'b0}};
            r_flags     <= 3'b000;
            r_tx_data   <= 8'h00;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_ld_a) begin
                r_dato_a <= w_rx_operand;
            end
            if (w_ld_b) begin
                r_dato_b <= w_rx_operand;
            end
            if (w_ld_op) begin
                r_operacion <= i_rx_data[NB_OP-1:0];
            end
            if (w_ld_exec) begin
                r_result <= i_resultado;
                r_flags  <= {i_carry, i_overflow, i_zero};
            end
            // tx_data changes together with the start pulse and is held until the next send.
            if (w_start_res) begin
                r_tx_data <= w_res_byte;
            end else if (w_start_flg) begin
                r_tx_data <= {5'b00000, r_flags};
            end
            r_tx_start <= w_start_res | w_start_flg;
            r_busy     <= (w_state_next != WAIT_A);
        end
    end

    assign o_datoA     = r_dato_a;
    assign o_datoB     = r_dato_b;
    assign o_operacion = r_operacion;
    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Randomised and directed bench for alu_uart_interface with a reference ALU
// driving the result/flag inputs and a frame-level expected-byte model.
module tb_alu_uart_interface;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_resultado;
    logic       i_zero, i_overflow, i_carry;
    logic [7:0] o_datoA, o_datoB, o_tx_data;
    logic [5:0] o_operacion;
    logic       o_tx_start, o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_uart_interface #(.N(8), .NB_OP(6)) dut (
        .clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_tx_done(i_tx_done), .i_resultado(i_resultado), .i_zero(i_zero),
        .i_overflow(i_overflow), .i_carry(i_carry), .o_datoA(o_datoA), .o_datoB(o_datoB),
        .o_operacion(o_operacion), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .o_busy(o_busy)
    );

    // Reference ALU: returns {carry, overflow, zero, result[7:0]}.
    function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        c = 1'b0; v = 1'b0; s = 9'd0;
        case (op)
            6'h20: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            6'h22: begin
                r = a - b; c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h27:   r = ~(a | b);
            6'h02:   r = a >> b[2:0];
            6'h03:   r = $signed(a) >>> b[2:0];
            default: r = 8'h00;
        endcase
        return {c, v, (r == 8'h00), r};
    endfunction

    logic [10:0] alu_out;
    assign alu_out     = alu_ref(o_datoA, o_datoB, o_operacion);
    assign i_resultado = alu_out[7:0];
    assign i_zero      = alu_out[8];
    assign i_overflow  = alu_out[9];
    assign i_carry     = alu_out[10];

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
    endtask

    // Waits (bounded) for a tx_start pulse, checks its byte and that it lasts one cycle.
    task automatic expect_tx(input string name, input logic [7:0] exp);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (o_tx_start === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            $display("FAIL %s: no tx_start within 40 cycles, wanted data 0x%02h", name, exp);
        end else if (o_tx_data !== exp) begin
            $display("FAIL %s: tx_data=0x%02h expected 0x%02h", name, o_tx_data, exp);
        end else begin
            n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (o_tx_start !== 1'b0) $display("FAIL %s_pulse: tx_start=%b expected 0", name, o_tx_start);
        else n_pass++;
    endtask

    // Full frame: three bytes in, result byte and flags byte out, with handshakes.
    task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op);
        logic [10:0] e;
        e = alu_ref(a, b, op[5:0]);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        n_checks++;
        if ({o_datoA, o_datoB, o_operacion} !== {a, b, op[5:0]})
            $display("FAIL %s_operands: A=%02h B=%02h OP=%02h expected %02h %02h %02h",
                     name, o_datoA, o_datoB, o_operacion, a, b, op[5:0]);
        else n_pass++;
        expect_tx({name, "_res"}, e[7:0]);
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL %s_hold: tx_start=%b busy=%b expected 0 1", name, o_tx_start, o_busy);
        else n_pass++;
        pulse_tx_done();
        expect_tx({name, "_flg"}, {5'b00000, e[10:8]});
        pulse_tx_done();
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL %s_idle: busy=%b expected 0", name, o_busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_rx_data = 8'h00; i_rx_done = 1'b0; i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_datoA, o_datoB, o_operacion, o_tx_data, o_tx_start, o_busy} !== 32'd0)
            $display("FAIL reset: A=%02h B=%02h OP=%02h TX=%02h start=%b busy=%b expected all 0",
                     o_datoA, o_datoB, o_operacion, o_tx_data, o_tx_start, o_busy);
        else n_pass++;
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_frame("add", 8'h05, 8'h03, 8'h20);
        run_frame("sub_zero", 8'h07, 8'h07, 8'h22);
        run_frame("add_ovf", 8'h7F, 8'h01, 8'h20);
        run_frame("add_carry", 8'hFF, 8'h01, 8'h20);
    endtask

    task automatic test_latency();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h25);
        @(negedge clk);
        n_checks++;
        if (o_tx_start !== 1'b0) $display("FAIL latency_early: tx_start=%b expected 0", o_tx_start);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h33)
            $display("FAIL latency: tx_start=%b data=%02h expected 1 33", o_tx_start, o_tx_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        pulse_tx_done();
        expect_tx("latency_flg", 8'h00);
        pulse_tx_done();
    endtask

    task automatic test_ignored_inputs();
        // Stray tx_done while collecting operands must not advance anything.
        send_byte(8'h05);
        pulse_tx_done();
        send_byte(8'h03);
        send_byte(8'h20);
        expect_tx("extra_res", 8'h08);
        send_byte(8'hAA);
        n_checks++;
        if (o_datoA !== 8'h05 || o_datoB !== 8'h03)
            $display("FAIL extra_byte: A=%02h B=%02h expected 05 03", o_datoA, o_datoB);
        else n_pass++;
        // rx_done and tx_done together in WAIT_TX_RES: only tx_done acts.
        @(negedge clk);
        i_rx_data = 8'h55; i_rx_done = 1'b1; i_tx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0; i_tx_done = 1'b0;
        expect_tx("simul_flg", 8'h00);
        n_checks++;
        if (o_datoA !== 8'h05) $display("FAIL simul_a: A=%02h expected 05", o_datoA);
        else n_pass++;
        pulse_tx_done();
        run_frame("after_extra", 8'h01, 8'h01, 8'h20);
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h10);
        send_byte(8'h20);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o_datoA, o_datoB, o_operacion, o_tx_data, o_tx_start, o_busy} !== 32'd0)
            $display("FAIL reset_mid: A=%02h B=%02h OP=%02h TX=%02h start=%b busy=%b expected all 0",
                     o_datoA, o_datoB, o_operacion, o_tx_data, o_tx_start, o_busy);
        else n_pass++;
        i_reset = 1'b0;
        // One byte after release must not complete the aborted frame.
        send_byte(8'h24);
        repeat (5) @(negedge clk);
        n_checks++;
        if (o_tx_start !== 1'b0 || o_datoA !== 8'h24)
            $display("FAIL reset_abort: start=%b A=%02h expected 0 24", o_tx_start, o_datoA);
        else n_pass++;
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        run_frame("post_reset", 8'h03, 8'h04, 8'h24);
    endtask

    task automatic test_opcode_mask();
        run_frame("op_mask", 8'h5A, 8'h0F, 8'hE6);
        n_checks++;
        if (o_operacion !== 6'h26) $display("FAIL op_mask_val: op=%02h expected 26", o_operacion);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] ops [8];
        logic [7:0] a, b, op;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
        for (int k = 0; k < 20; k++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame($sformatf("rand%0d", k), a, b, op);
            n_checks++;
            if (o_datoA !== a || o_datoB !== b)
                $display("FAIL rand%0d_keep: A=%02h B=%02h expected %02h %02h", k, o_datoA, o_datoB, a, b);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_ignored_inputs();
        test_reset_midframe();
        test_opcode_mask();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
